// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register, one-entry skid buffer for
// downstream stalls, and redirect handling that respects the I-cache address-hold rule.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INST    = 32'h0000_0013,
    parameter bit          SWAP_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        icache_ren_o,
    output logic [29:0] icache_addr_o,
    input  logic [31:0] icache_rdata_i,
    input  logic        icache_stall_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        valid_o
);

    localparam logic [1:0] S_FETCH    = 2'd0;
    localparam logic [1:0] S_BUFFERED = 2'd1;
    localparam logic [1:0] S_DISCARD  = 2'd2;

    logic [1:0]  state_q;
    logic [31:0] pc_q;
    logic [31:0] saved_target_q;
    logic [31:0] buf_inst_q;
    logic [31:0] buf_pc_q;
    logic [31:0] fetched_word;
    logic [31:0] target;
    logic        unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc_i[1:0];
    assign target         = {redirect_pc_i[31:2], 2'b00};
    assign fetched_word   = SWAP_ENDIAN ? {icache_rdata_i[7:0], icache_rdata_i[15:8],
                                           icache_rdata_i[23:16], icache_rdata_i[31:24]}
                                        : icache_rdata_i;

    // The skid buffer owns the next instruction, so no read is issued while it is full.
    assign icache_ren_o  = !rst && (state_q != S_BUFFERED);
    assign icache_addr_o = pc_q[31:2];

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would let pc_q updates leak into pc_o.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_FETCH;
            pc_q           <= RESET_PC;
            saved_target_q <= 32'h0;
            buf_inst_q     <= 32'h0;
            buf_pc_q       <= 32'h0;
            inst_o         <= NOP_INST;
            pc_o           <= 32'h0;
            valid_o        <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (redirect_i) begin
                        // A stalled cache keeps its address; park the target until it finishes.
                        if (icache_stall_i) begin
                            saved_target_q <= target;
                            state_q        <= S_DISCARD;
                        end else begin
                            pc_q <= target;
                        end
                        inst_o  <= NOP_INST;
                        pc_o    <= pc_q;
                        valid_o <= 1'b0;
                    end else if (!icache_stall_i) begin
                        if (!stall_i) begin
                            inst_o  <= fetched_word;
                            pc_o    <= pc_q;
                            valid_o <= 1'b1;
                        end else begin
                            buf_inst_q <= fetched_word;
                            buf_pc_q   <= pc_q;
                            state_q    <= S_BUFFERED;
                        end
                        pc_q <= pc_q + 32'd4;
                    end else if (!stall_i) begin
                        inst_o  <= NOP_INST;
                        pc_o    <= pc_q;
                        valid_o <= 1'b0;
                    end
                end

                S_BUFFERED: begin
                    if (redirect_i) begin
                        pc_q    <= target;
                        state_q <= S_FETCH;
                        inst_o  <= NOP_INST;
                        pc_o    <= pc_q;
                        valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        inst_o  <= buf_inst_q;
                        pc_o    <= buf_pc_q;
                        valid_o <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end

                S_DISCARD: begin
                    if (redirect_i) begin
                        saved_target_q <= target;
                    end
                    if (!icache_stall_i) begin
                        pc_q    <= redirect_i ? target : saved_target_q;
                        state_q <= S_FETCH;
                    end
                    if (redirect_i || !stall_i) begin
                        inst_o  <= NOP_INST;
                        pc_o    <= pc_q;
                        valid_o <= 1'b0;
                    end
                end

                default: state_q <= S_FETCH;
            endcase
        end
    end

endmodule
